// File: rtl/serial_adder_pkg.sv
// Shared types and default sizing for the serial_adder block.
package serial_adder_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DIGIT_W = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Start/ready/done handshake and operand/result bus of serial_adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input ready, busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output ready, busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input ready, busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output ready, busy, done, sum, cout, ovf);
`endif

endinterface

// File: rtl/digit_adder.sv
// Combinational DIGIT_W-bit ripple of full_adder cells; also exposes the
// carry into the digit MSB so the caller can derive signed overflow.
module digit_adder #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] da_i,
  input  logic [DIGIT_W-1:0] db_i,
  input  logic               dcin_i,
  output logic [DIGIT_W-1:0] dsum_o,
  output logic               dcout_o,
  output logic               dcmsb_o
);

  logic [DIGIT_W:0] c;

  assign c[0] = dcin_i;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
    full_adder u_fa (
      .a_i  (da_i[i]),
      .b_i  (db_i[i]),
      .ci_i (c[i]),
      .s_o  (dsum_o[i]),
      .co_o (c[i+1])
    );
  end

  assign dcout_o = c[DIGIT_W];
  assign dcmsb_o = c[DIGIT_W-1];

endmodule

// File: rtl/full_adder.sv
// One-bit combinational full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed DIGIT_W bits per clock through
// one carry flop. Define SERIAL_ADDER_SUB_EN to add the subtract (sub) option.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int K     = WIDTH / DIGIT_W;
  localparam int CNT_W = $clog2(K + 1);

  if (DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_bad_cfg
    $fatal(1, "serial_adder: WIDTH must be a positive multiple of DIGIT_W");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   b_in;
  logic               c_in;
  logic [DIGIT_W-1:0] dsum;
  logic               dcout;
  logic               dcmsb;
  logic [WIDTH-1:0]   sh_shift;
  logic               ready, busy, done;

  // Subtraction is a + ~b + 1, so it reuses the adder path unchanged.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_in = bus.sub ? ~bus.b : bus.b;
  assign c_in = bus.sub | bus.cin;
`else
  assign b_in = bus.b;
  assign c_in = bus.cin;
`endif

  digit_adder #(.DIGIT_W(DIGIT_W)) u_digit (
    .da_i    (a_q[DIGIT_W-1:0]),
    .db_i    (b_q[DIGIT_W-1:0]),
    .dcin_i  (carry_q),
    .dsum_o  (dsum),
    .dcout_o (dcout),
    .dcmsb_o (dcmsb)
  );

  // Digits arrive LSB first, so each one enters at the top and slides down.
  always_comb begin
    sh_shift = sh_q >> DIGIT_W;
    sh_shift[WIDTH-1 -: DIGIT_W] = dsum;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = b_in;
          carry_d = c_in;
          sh_d    = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        busy    = 1'b1;
        a_d     = a_q >> DIGIT_W;
        b_d     = b_q >> DIGIT_W;
        sh_d    = sh_shift;
        carry_d = dcout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(K - 1)) begin
          state_d = DONE;
          sum_d   = sh_shift;
          cout_d  = dcout;
          ovf_d   = dcout ^ dcmsb;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state elements use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ready = ready;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (DIGIT_W = 1, 4, 8) share one
// stimulus stream and are compared every cycle against a timing/arithmetic model.
module tb_serial_adder;

  localparam int W = 8;
  localparam int ND = 3;
`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic         start_r = 1'b0;
  logic [W-1:0] a_r     = '0;
  logic [W-1:0] b_r     = '0;
  logic         cin_r   = 1'b0;
  logic         sub_r   = 1'b0;

  logic [ND-1:0]        ready_w, busy_w, done_w, cout_w, ovf_w;
  logic [ND-1:0][W-1:0] sum_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    serial_adder_if #(.WIDTH(W)) bus ();
    assign bus.start = start_r;
    assign bus.a     = a_r;
    assign bus.b     = b_r;
    assign bus.cin   = cin_r;
`ifdef SERIAL_ADDER_SUB_EN
    assign bus.sub   = sub_r;
`endif
    serial_adder #(.WIDTH(W), .DIGIT_W(g == 0 ? 1 : (g == 1 ? 4 : 8))) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
    assign ready_w[g] = bus.ready;
    assign busy_w[g]  = bus.busy;
    assign done_w[g]  = bus.done;
    assign sum_w[g]   = bus.sum;
    assign cout_w[g]  = bus.cout;
    assign ovf_w[g]   = bus.ovf;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: an operation accepted at edge T occupies cycles T+1..T+K (busy)
  // and T+K+1 (done); outside that window the instance is ready.
  int           cyc = 0;
  int           t_acc    [ND] = '{-100, -100, -100};
  logic [W-1:0] res_sum  [ND];
  logic         res_cout [ND];
  logic         res_ovf  [ND];
  logic [W-1:0] held_sum [ND] = '{default: '0};
  logic         held_cout[ND] = '{default: 1'b0};
  logic         held_ovf [ND] = '{default: 1'b0};

  int done_cnt[ND];
  int busy_cnt[ND];
  int done_cyc[ND];

  function automatic int k_of(input int d);
    return (d == 0) ? 8 : ((d == 1) ? 2 : 1);
  endfunction

  function automatic bit in_win(input int d, input int c);
    return (c >= t_acc[d] + 1) && (c <= t_acc[d] + k_of(d) + 1);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        t_acc[d] = -100;
      end else if (!in_win(d, cyc) && start_r) begin
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         c0;
        bb = b_r;
        c0 = cin_r;
        if (SUB_EN && sub_r) begin
          bb = ~b_r;
          c0 = 1'b1;
        end
        full        = {1'b0, a_r} + {1'b0, bb} + {{W{1'b0}}, c0};
        t_acc[d]    = cyc;
        res_sum[d]  = full[W-1:0];
        res_cout[d] = full[W];
        res_ovf[d]  = (a_r[W-1] == bb[W-1]) && (full[W-1] != a_r[W-1]);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        t_acc[d]     = -100;
        held_sum[d]  = '0;
        held_cout[d] = 1'b0;
        held_ovf[d]  = 1'b0;
      end
      if (cyc == t_acc[d] + k_of(d) + 1) begin
        held_sum[d]  = res_sum[d];
        held_cout[d] = res_cout[d];
        held_ovf[d]  = res_ovf[d];
      end
      check($sformatf("ready[%0d] cyc %0d", d, cyc), ready_w[d],
            !(in_win(d, cyc) && !rst));
      check($sformatf("busy[%0d] cyc %0d", d, cyc), busy_w[d],
            !rst && cyc >= t_acc[d] + 1 && cyc <= t_acc[d] + k_of(d));
      check($sformatf("done[%0d] cyc %0d", d, cyc), done_w[d],
            !rst && cyc == t_acc[d] + k_of(d) + 1);
      check($sformatf("sum[%0d] cyc %0d", d, cyc), sum_w[d], held_sum[d]);
      check($sformatf("cout[%0d] cyc %0d", d, cyc), cout_w[d], held_cout[d]);
      check($sformatf("ovf[%0d] cyc %0d", d, cyc), ovf_w[d], held_ovf[d]);
      if (done_w[d] === 1'b1) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
      end
      if (busy_w[d] === 1'b1) busy_cnt[d]++;
    end
  end

  task automatic clear_stats();
    for (int d = 0; d < ND; d++) begin
      done_cnt[d] = 0;
      busy_cnt[d] = 0;
      done_cyc[d] = -1;
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    @(negedge clk); #1;
    start_r = 1'b1;
    a_r     = a;
    b_r     = b;
    cin_r   = c;
    sub_r   = s;
    @(negedge clk); #1;
    start_r = 1'b0;
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
    #2;
  endtask

  task automatic expect_res(input string tag, input int d, input logic [W-1:0] s,
                            input logic co, input logic ov);
    check({tag, " sum"}, sum_w[d], s);
    check({tag, " cout"}, cout_w[d], co);
    check({tag, " ovf"}, ovf_w[d], ov);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Basic add with latency and busy length on the bit-serial instance.
    clear_stats();
    do_op(8'h0F, 8'h01, 1'b0, 1'b0);
    settle();
    expect_res("basic", 0, 8'h10, 1'b0, 1'b0);
    check("basic busy cycles", busy_cnt[0], 8);
    check("basic done count", done_cnt[0], 1);
    check("basic latency d1", done_cyc[0] - t_acc[0], 9);

    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    settle();
    expect_res("ff+01", 0, 8'h00, 1'b1, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0);
    settle();
    expect_res("7f+01", 0, 8'h80, 1'b0, 1'b1);
    do_op(8'h00, 8'h00, 1'b1, 1'b0);
    settle();
    expect_res("cin only", 0, 8'h01, 1'b0, 1'b0);

    // Wide digits.
    clear_stats();
    do_op(8'h9C, 8'h78, 1'b0, 1'b0);
    settle();
    for (int d = 0; d < ND; d++) expect_res($sformatf("9c+78[%0d]", d), d, 8'h14, 1'b1, 1'b0);
    check("latency d4", done_cyc[1] - t_acc[1], 3);
    check("latency d8", done_cyc[2] - t_acc[2], 2);

    // Start during RUN is ignored on the bit-serial instance.
    clear_stats();
    do_op(8'h11, 8'h22, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    do_op(8'hAA, 8'h22, 1'b0, 1'b0);
    settle();
    check("handshake done count", done_cnt[0], 1);
    check("handshake sum", sum_w[0], 8'h33);
    clear_stats();
    do_op(8'h01, 8'h02, 1'b0, 1'b0);
    settle();
    check("second op done count", done_cnt[0], 1);
    check("second op sum", sum_w[0], 8'h03);

    // Reset during the 4th RUN cycle of the bit-serial instance.
    clear_stats();
    do_op(8'h55, 8'h33, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("reset sum", sum_w[0], 8'h00);
    check("reset ready", ready_w[0], 1'b1);
    check("reset busy", busy_w[0], 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;
    settle();
    check("reset no done", done_cnt[0], 0);
    clear_stats();
    do_op(8'h05, 8'h03, 1'b0, 1'b0);
    settle();
    expect_res("after reset", 0, 8'h08, 1'b0, 1'b0);
    check("after reset latency", done_cyc[0] - t_acc[0], 9);

    if (SUB_EN) begin
      do_op(8'h05, 8'h07, 1'b0, 1'b1);
      settle();
      expect_res("sub 05-07", 0, 8'hFE, 1'b0, 1'b0);
      do_op(8'h80, 8'h01, 1'b0, 1'b1);
      settle();
      expect_res("sub 80-01", 0, 8'h7F, 1'b1, 1'b1);
    end

    // Randomized traffic, including back-to-back starts and rare resets.
    repeat (600) begin
      @(negedge clk); #1;
      start_r = ($urandom_range(0, 2) != 0);
      a_r     = W'($urandom);
      b_r     = W'($urandom);
      cin_r   = 1'($urandom);
      sub_r   = SUB_EN ? 1'($urandom) : 1'b0;
      rst     = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk); #1;
    start_r = 1'b0;
    rst     = 1'b0;
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
